gb_square_channel: RTL

Parametrised square-wave tone generator with frequency sweep, length counter and volume envelope. It generalises the fixed channel-1 register decode into a reusable channel: it is instantiated once with sweep for channel 1 and once without sweep for channel 2. It sits on the CPU I/O bus at BASE_ADDR..BASE_ADDR+4 and feeds an unsigned sample to the sound mixer.

---
 rtl/gb_square_channel.sv | 267 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/gb_square_channel.sv
// gb_square_channel: square-wave tone channel with optional frequency sweep,
// length counter and volume envelope, mapped at BASE_ADDR..BASE_ADDR+4.
// Optional register readback is enabled by defining GB_SQUARE_READBACK_EN;
// without it every read of the block returns 0xFF.
module gb_square_channel #(
   parameter logic [15:0] BASE_ADDR = 16'hFF10,
   parameter int unsigned HAS_SWEEP = 1,
   parameter int unsigned FREQ_W    = 11,
   parameter int unsigned LEN_W     = 6,
   parameter int unsigned VOL_W     = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [15:0]      addr,
   input  logic             wr_en,
   input  logic [7:0]       data_in,
   input  logic             rd_en,
   output logic [7:0]       data_out,
   output logic             hit,
   input  logic             timer_tick,
   input  logic             frame_tick,
   output logic [VOL_W-1:0] sample,
   output logic             active
);

   localparam int unsigned TW = FREQ_W + 1;
   localparam int unsigned LW = LEN_W + 1;
   localparam logic [TW-1:0] FREQ_SPAN = TW'(2**FREQ_W);
   localparam logic [LW-1:0] LEN_FULL  = LW'(2**LEN_W);
   localparam logic          SWEEP_ON  = (HAS_SWEEP != 0);

   // register file and channel state
   logic [6:0]        nr0_q, nr0_n;
   logic [1:0]        duty_q, duty_n;
   logic [7:0]        nr2_q, nr2_n;
   logic              len_en_q, len_en_n;
   logic [FREQ_W-1:0] freq_q, freq_n;
   logic [LW-1:0]     len_q, len_n;
   logic [TW-1:0]     tmr_q, tmr_n;
   logic [2:0]        step_q, step_n;
   logic [2:0]        fstep_q, fstep_n;
   logic [VOL_W-1:0]  vol_q, vol_n;
   logic [2:0]        env_tmr_q, env_tmr_n;
   logic [FREQ_W-1:0] shadow_q, shadow_n;
   logic [3:0]        sw_tmr_q, sw_tmr_n;
   logic              sw_en_q, sw_en_n;
   logic              active_n;
   logic [VOL_W-1:0]  sample_n;
   logic [7:0]        data_out_n;

   logic [15:0]       offset;
   logic [2:0]        reg_idx;
   logic              trig;
   logic              dac_on;
   logic [2:0]        sw_time;
   logic              sw_neg;
   logic [2:0]        sw_shift;
   logic [FREQ_W:0]   sw_res;
   logic [FREQ_W:0]   sw_chk;
   logic [7:0]        duty_bits;
   logic [7:0]        rd_val;

   // next sweep frequency; bit FREQ_W set means overflow
   function automatic logic [FREQ_W:0] sweep_calc(input logic [FREQ_W-1:0] base,
                                                  input logic              neg,
                                                  input logic [2:0]        shift);
      logic [FREQ_W:0] delta;
      delta = {1'b0, base >> shift};
      sweep_calc = neg ? ({1'b0, base} - delta) : ({1'b0, base} + delta);
   endfunction

   // address decode; wraps below BASE_ADDR so a single compare suffices
   always_comb begin
      offset  = addr - BASE_ADDR;
      hit     = (offset <= 16'd4);
      reg_idx = offset[2:0];
   end

   // duty waveform, bit i is the level at duty step i
   always_comb begin
      duty_bits = 8'h00;
      case (duty_q)
         2'b00:   duty_bits = 8'b1000_0000;
         2'b01:   duty_bits = 8'b1000_0001;
         2'b10:   duty_bits = 8'b1110_0001;
         default: duty_bits = 8'b0111_1110;
      endcase
   end

   // read data: register value with unreadable bits forced high
   always_comb begin
      rd_val = 8'hFF;
`ifdef GB_SQUARE_READBACK_EN
      case (reg_idx)
         3'd0:    rd_val = SWEEP_ON ? {1'b1, nr0_q} : 8'hFF;
         3'd1:    rd_val = {duty_q, 6'h3F};
         3'd2:    rd_val = nr2_q;
         3'd4:    rd_val = {1'b1, len_en_q, 6'h3F};
         default: rd_val = 8'hFF;
      endcase
`endif
   end

   // next state: register writes first, then trigger, then frame and timer ticks
   always_comb begin
      nr0_n     = nr0_q;
      duty_n    = duty_q;
      nr2_n     = nr2_q;
      len_en_n  = len_en_q;
      freq_n    = freq_q;
      len_n     = len_q;
      tmr_n     = tmr_q;
      step_n    = step_q;
      fstep_n   = fstep_q;
      vol_n     = vol_q;
      env_tmr_n = env_tmr_q;
      shadow_n  = shadow_q;
      sw_tmr_n  = sw_tmr_q;
      sw_en_n   = sw_en_q;
      active_n  = active;
      trig      = 1'b0;
      sw_res    = '0;
      sw_chk    = '0;

      if (wr_en && hit) begin
         case (reg_idx)
            3'd0: if (SWEEP_ON) nr0_n = data_in[6:0];
            3'd1: begin
               duty_n = data_in[7:6];
               len_n  = LEN_FULL - LW'(data_in[LEN_W-1:0]);
            end
            3'd2: begin
               nr2_n = data_in;
               if (data_in[7:3] == 5'd0) active_n = 1'b0;
            end
            3'd3: freq_n[7:0] = data_in;
            3'd4: begin
               len_en_n           = data_in[6];
               freq_n[FREQ_W-1:8] = data_in[FREQ_W-9:0];
               trig               = data_in[7];
            end
            default: ;
         endcase
      end

      dac_on   = (nr2_n[7:3] != 5'd0);
      sw_time  = nr0_n[6:4];
      sw_neg   = nr0_n[3];
      sw_shift = nr0_n[2:0];

      if (trig) begin
         active_n  = dac_on;
         if (len_n == '0) len_n = LEN_FULL;
         tmr_n     = FREQ_SPAN - TW'(freq_n);
         vol_n     = nr2_n[7 -: VOL_W];
         env_tmr_n = nr2_n[2:0];
         if (SWEEP_ON) begin
            shadow_n = freq_n;
            sw_tmr_n = (sw_time == 3'd0) ? 4'd8 : {1'b0, sw_time};
            sw_en_n  = (sw_time != 3'd0) || (sw_shift != 3'd0);
            if (sw_shift != 3'd0) begin
               sw_res = sweep_calc(freq_n, sw_neg, sw_shift);
               if (sw_res[FREQ_W]) active_n = 1'b0;
            end
         end
      end

      if (frame_tick) begin
         fstep_n = fstep_q + 3'd1;

         // length clock on even steps; a same-cycle trigger takes priority
         if (!fstep_q[0] && !trig && len_en_n && (len_n != '0)) begin
            len_n = len_n - LW'(1);
            if (len_n == '0) active_n = 1'b0;
         end

         // sweep clock on steps 2 and 6
         if (SWEEP_ON && (fstep_q[1:0] == 2'b10)) begin
            if (sw_tmr_n <= 4'd1) begin
               sw_tmr_n = (sw_time == 3'd0) ? 4'd8 : {1'b0, sw_time};
               if (sw_en_n && (sw_time != 3'd0)) begin
                  sw_res = sweep_calc(shadow_n, sw_neg, sw_shift);
                  if (sw_res[FREQ_W]) begin
                     active_n = 1'b0;
                  end else if (sw_shift != 3'd0) begin
                     shadow_n = sw_res[FREQ_W-1:0];
                     freq_n   = sw_res[FREQ_W-1:0];
                     sw_chk   = sweep_calc(sw_res[FREQ_W-1:0], sw_neg, sw_shift);
                     if (sw_chk[FREQ_W]) active_n = 1'b0;
                  end
               end
            end else begin
               sw_tmr_n = sw_tmr_n - 4'd1;
            end
         end

         // envelope clock on step 7; period 0 freezes the volume
         if ((fstep_q == 3'd7) && (nr2_n[2:0] != 3'd0)) begin
            if (env_tmr_n <= 3'd1) begin
               env_tmr_n = nr2_n[2:0];
               if (nr2_n[3]) begin
                  if (vol_n != {VOL_W{1'b1}}) vol_n = vol_n + VOL_W'(1);
               end else begin
                  if (vol_n != '0) vol_n = vol_n - VOL_W'(1);
               end
            end else begin
               env_tmr_n = env_tmr_n - 3'd1;
            end
         end
      end

      // frequency timer; a same-cycle trigger reload takes priority
      if (timer_tick && !trig) begin
         if (tmr_q <= TW'(1)) begin
            tmr_n  = FREQ_SPAN - TW'(freq_n);
            step_n = step_q + 3'd1;
         end else begin
            tmr_n = tmr_q - TW'(1);
         end
      end

      sample_n   = (active && duty_bits[step_q]) ? vol_q : '0;
      data_out_n = (rd_en && hit) ? rd_val : data_out;
   end

   // state registers with synchronous reset
   always_ff @(posedge clock) begin
      if (reset) begin
         nr0_q     <= '0;
         duty_q    <= '0;
         nr2_q     <= '0;
         len_en_q  <= 1'b0;
         freq_q    <= '0;
         len_q     <= '0;
         tmr_q     <= '0;
         step_q    <= '0;
         fstep_q   <= '0;
         vol_q     <= '0;
         env_tmr_q <= '0;
         shadow_q  <= '0;
         sw_tmr_q  <= '0;
         sw_en_q   <= 1'b0;
         active    <= 1'b0;
         sample    <= '0;
         data_out  <= '0;
      end else begin
         nr0_q     <= nr0_n;
         duty_q    <= duty_n;
         nr2_q     <= nr2_n;
         len_en_q  <= len_en_n;
         freq_q    <= freq_n;
         len_q     <= len_n;
         tmr_q     <= tmr_n;
         step_q    <= step_n;
         fstep_q   <= fstep_n;
         vol_q     <= vol_n;
         env_tmr_q <= env_tmr_n;
         shadow_q  <= shadow_n;
         sw_tmr_q  <= sw_tmr_n;
         sw_en_q   <= sw_en_n;
         active    <= active_n;
         sample    <= sample_n;
         data_out  <= data_out_n;
      end
   end

endmodule
